// File: rtl/toki_seibu_pkg.sv
// Shared offsets and vector constants for the Toki 68K <-> Seibu Z80 mailbox.
package toki_seibu_pkg;

    typedef enum logic [2:0] {
        MO_M2S0   = 3'd0,
        MO_M2S1   = 3'd1,
        MO_S2M0   = 3'd2,
        MO_S2M1   = 3'd3,
        MO_RST18  = 3'd4,
        MO_PEND   = 3'd5,
        MO_S2MCLR = 3'd6,
        MO_NOP    = 3'd7
    } main_off_e;

    typedef enum logic [4:0] {
        ZO_PEND    = 5'h00,
        ZO_ACK_ALL = 5'h01,
        ZO_ACK10   = 5'h02,
        ZO_ACK18   = 5'h03,
        ZO_M2S0    = 5'h10,
        ZO_M2S1    = 5'h11,
        ZO_M2SPEND = 5'h12,
        ZO_S2M0    = 5'h18,
        ZO_S2M1    = 5'h19
    } z80_off_e;

    localparam logic [7:0] VEC_RST10_DEF = 8'hD7;
    localparam logic [7:0] VEC_RST18_DEF = 8'hDF;
    localparam logic [7:0] VEC_IDLE      = 8'hFF;

    // IM0 opcode: each pending RST pulls its bits low, so both pending yields RST10.
    function automatic logic [7:0] irq_vector(input logic       r10,
                                              input logic       r18,
                                              input logic [7:0] v10,
                                              input logic [7:0] v18);
        return VEC_IDLE & (r10 ? v10 : VEC_IDLE) & (r18 ? v18 : VEC_IDLE);
    endfunction

endpackage

// File: rtl/toki_irq_sched.sv
// Z80 interrupt request bookkeeping: YM edge detect, RST10/RST18 requests, INT_n and IM0 vector.
module toki_irq_sched
    import toki_seibu_pkg::*;
#(
    parameter logic [7:0] VEC_RST10 = VEC_RST10_DEF,
    parameter logic [7:0] VEC_RST18 = VEC_RST18_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ym_irq,
    input  logic       rst18_set,
    input  logic       rst10_clr,
    input  logic       rst18_clr,
    output logic       int_n,
    output logic [7:0] vector
);

    logic       ym_q;
    logic       rst10_q, rst10_d;
    logic       rst18_q, rst18_d;
    logic [7:0] vector_q, vector_d;
    logic       int_n_q, int_n_d;
    logic       ym_rise;

    assign ym_rise = ym_irq & ~ym_q;

    // Set is applied after clear so a coincident ack never loses a request.
    always_comb begin
        rst10_d = rst10_q;
        rst18_d = rst18_q;
        if (rst10_clr) rst10_d = 1'b0;
        if (ym_rise)   rst10_d = 1'b1;
        if (rst18_clr) rst18_d = 1'b0;
        if (rst18_set) rst18_d = 1'b1;
        vector_d = irq_vector(rst10_q, rst18_q, VEC_RST10, VEC_RST18);
        int_n_d  = (vector_d == VEC_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ym_q     <= 1'b0;
            rst10_q  <= 1'b0;
            rst18_q  <= 1'b0;
            vector_q <= VEC_IDLE;
            int_n_q  <= 1'b1;
        end else begin
            ym_q     <= ym_irq;
            rst10_q  <= rst10_d;
            rst18_q  <= rst18_d;
            vector_q <= vector_d;
            int_n_q  <= int_n_d;
        end
    end

    assign int_n  = int_n_q;
    assign vector = vector_q;

endmodule

// File: rtl/toki_seibu_comms.sv
// 68K <-> Seibu Z80 mailbox: byte latches, pending flags, decode and read muxes.
module toki_seibu_comms
    import toki_seibu_pkg::*;
#(
    parameter logic [7:0] VEC_RST10 = VEC_RST10_DEF,
    parameter logic [7:0] VEC_RST18 = VEC_RST18_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        main_cs,
    input  logic        main_we,
    input  logic [2:0]  main_addr,
    input  logic [7:0]  main_din,
    output logic [15:0] main_dout,
    input  logic        z80_cs,
    input  logic        z80_we,
    input  logic [4:0]  z80_addr,
    input  logic [7:0]  z80_din,
    output logic [7:0]  z80_dout,
    input  logic        ym_irq,
    output logic        z80_int_n,
    output logic [7:0]  z80_vector,
    output logic [7:0]  m2s_0,
    output logic [7:0]  m2s_1
);

    logic        main_wr_q, z80_wr_q;
    logic        main_wev, z80_wev;
    logic [7:0]  m2s_0_q, m2s_1_q, s2m_0_q, s2m_1_q;
    logic        m2s_pend_q, m2s_pend_d;
    logic        s2m_pend_q, s2m_pend_d;
    logic [15:0] main_dout_q;
    logic [7:0]  z80_dout_q;
    logic [7:0]  main_rdata, z80_rdata;

    logic m2s0_we, m2s1_we, rst18_set, s2m_clr;
    logic s2m0_we, s2m1_we, m2s_clr, s2m_set, rst10_clr, rst18_clr;

    // One event per access: only the cycle where cs&we first rises acts.
    assign main_wev = main_cs & main_we & ~main_wr_q;
    assign z80_wev  = z80_cs & z80_we & ~z80_wr_q;

    always_comb begin
        m2s0_we   = 1'b0;
        m2s1_we   = 1'b0;
        rst18_set = 1'b0;
        s2m_clr   = 1'b0;
        if (main_wev) begin
            case (main_off_e'(main_addr))
                MO_M2S0:   m2s0_we   = 1'b1;
                MO_M2S1:   m2s1_we   = 1'b1;
                MO_RST18:  rst18_set = 1'b1;
                MO_S2MCLR: s2m_clr   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        s2m0_we   = 1'b0;
        s2m1_we   = 1'b0;
        m2s_clr   = 1'b0;
        s2m_set   = 1'b0;
        rst10_clr = 1'b0;
        rst18_clr = 1'b0;
        if (z80_wev) begin
            case (z80_off_e'(z80_addr))
                ZO_PEND: begin
                    m2s_clr = 1'b1;
                    s2m_set = 1'b1;
                end
                ZO_ACK_ALL: begin
                    rst10_clr = 1'b1;
                    rst18_clr = 1'b1;
                end
                ZO_ACK10: rst10_clr = 1'b1;
                ZO_ACK18: rst18_clr = 1'b1;
                ZO_S2M0:  s2m0_we   = 1'b1;
                ZO_S2M1:  s2m1_we   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        m2s_pend_d = rst18_set ? 1'b1 : (m2s_clr ? 1'b0 : m2s_pend_q);
        s2m_pend_d = s2m_set   ? 1'b1 : (s2m_clr ? 1'b0 : s2m_pend_q);
    end

    always_comb begin
        main_rdata = '0;
        case (main_off_e'(main_addr))
            MO_S2M0: main_rdata = s2m_0_q;
            MO_S2M1: main_rdata = s2m_1_q;
            MO_PEND: main_rdata = {7'd0, s2m_pend_q};
            default: main_rdata = '0;
        endcase
    end

    always_comb begin
        z80_rdata = '1;
        case (z80_off_e'(z80_addr))
            ZO_M2S0:    z80_rdata = m2s_0_q;
            ZO_M2S1:    z80_rdata = m2s_1_q;
            ZO_M2SPEND: z80_rdata = {7'd0, m2s_pend_q};
            default:    z80_rdata = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_wr_q   <= 1'b0;
            z80_wr_q    <= 1'b0;
            m2s_0_q     <= '0;
            m2s_1_q     <= '0;
            s2m_0_q     <= '0;
            s2m_1_q     <= '0;
            m2s_pend_q  <= 1'b0;
            s2m_pend_q  <= 1'b0;
            main_dout_q <= '0;
            z80_dout_q  <= '0;
        end else begin
            main_wr_q  <= main_cs & main_we;
            z80_wr_q   <= z80_cs & z80_we;
            m2s_pend_q <= m2s_pend_d;
            s2m_pend_q <= s2m_pend_d;
            if (m2s0_we) m2s_0_q <= main_din;
            if (m2s1_we) m2s_1_q <= main_din;
            if (s2m0_we) s2m_0_q <= z80_din;
            if (s2m1_we) s2m_1_q <= z80_din;
            if (main_cs) main_dout_q <= {8'h00, main_rdata};
            if (z80_cs)  z80_dout_q  <= z80_rdata;
        end
    end

    toki_irq_sched #(
        .VEC_RST10 (VEC_RST10),
        .VEC_RST18 (VEC_RST18)
    ) u_irq (
        .clk       (clk),
        .rst       (rst),
        .ym_irq    (ym_irq),
        .rst18_set (rst18_set),
        .rst10_clr (rst10_clr),
        .rst18_clr (rst18_clr),
        .int_n     (z80_int_n),
        .vector    (z80_vector)
    );

    assign main_dout = main_dout_q;
    assign z80_dout  = z80_dout_q;
    assign m2s_0     = m2s_0_q;
    assign m2s_1     = m2s_1_q;

endmodule

// File: tb/tb_toki_seibu_comms.sv
// Scoreboard bench for toki_seibu_comms: stimulus queues expectations, a monitor checks them.
module tb_toki_seibu_comms;

    logic        clk = 1'b0;
    logic        rst;
    logic        main_cs, main_we;
    logic [2:0]  main_addr;
    logic [7:0]  main_din;
    logic [15:0] main_dout;
    logic        z80_cs, z80_we;
    logic [4:0]  z80_addr;
    logic [7:0]  z80_din;
    logic [7:0]  z80_dout;
    logic        ym_irq;
    logic        z80_int_n;
    logic [7:0]  z80_vector;
    logic [7:0]  m2s_0, m2s_1;

    always #5 clk = ~clk;

    toki_seibu_comms #(
        .VEC_RST10 (8'hD7),
        .VEC_RST18 (8'hDF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .main_cs    (main_cs),
        .main_we    (main_we),
        .main_addr  (main_addr),
        .main_din   (main_din),
        .main_dout  (main_dout),
        .z80_cs     (z80_cs),
        .z80_we     (z80_we),
        .z80_addr   (z80_addr),
        .z80_din    (z80_din),
        .z80_dout   (z80_dout),
        .ym_irq     (ym_irq),
        .z80_int_n  (z80_int_n),
        .z80_vector (z80_vector),
        .m2s_0      (m2s_0),
        .m2s_1      (m2s_1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q_main[$];
    string       q_main_nm[$];
    logic [7:0]  q_z80[$];
    string       q_z80_nm[$];

    typedef struct {
        logic        chk_dout;
        logic [15:0] md;
        logic [7:0]  zd;
        logic        int_n;
        logic [7:0]  vec;
    } probe_t;
    probe_t q_probe[$];
    string  q_probe_nm[$];
    logic   probe = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a read result is presented one cycle after cs is sampled.
    logic mon_main = 1'b0;
    logic mon_z80  = 1'b0;
    always @(posedge clk) begin
        mon_main <= main_cs & ~main_we & ~rst;
        mon_z80  <= z80_cs & ~z80_we & ~rst;
    end

    always @(negedge clk) begin
        if (mon_main) begin
            if (q_main.size() == 0) chk("main_rd_unexpected", 16'd1, 16'd0);
            else chk(q_main_nm.pop_front(), main_dout, q_main.pop_front());
        end
        if (mon_z80) begin
            if (q_z80.size() == 0) chk("z80_rd_unexpected", 16'd1, 16'd0);
            else chk(q_z80_nm.pop_front(), {8'h00, z80_dout}, {8'h00, q_z80.pop_front()});
        end
        if (probe) begin
            if (q_probe.size() == 0) chk("probe_unexpected", 16'd1, 16'd0);
            else begin
                probe_t p;
                string  nm;
                p  = q_probe.pop_front();
                nm = q_probe_nm.pop_front();
                chk({nm, "_int_n"}, {15'd0, z80_int_n}, {15'd0, p.int_n});
                chk({nm, "_vec"}, {8'h00, z80_vector}, {8'h00, p.vec});
                if (p.chk_dout) begin
                    chk({nm, "_main_dout"}, main_dout, p.md);
                    chk({nm, "_z80_dout"}, {8'h00, z80_dout}, {8'h00, p.zd});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic main_wr(input logic [2:0] a, input logic [7:0] d);
        main_cs = 1'b1; main_we = 1'b1; main_addr = a; main_din = d;
        step();
        main_cs = 1'b0; main_we = 1'b0;
        step();
    endtask

    task automatic z80_wr(input logic [4:0] a, input logic [7:0] d);
        z80_cs = 1'b1; z80_we = 1'b1; z80_addr = a; z80_din = d;
        step();
        z80_cs = 1'b0; z80_we = 1'b0;
        step();
    endtask

    task automatic both_wr(input logic [2:0] ma, input logic [7:0] md,
                           input logic [4:0] za, input logic [7:0] zd);
        main_cs = 1'b1; main_we = 1'b1; main_addr = ma; main_din = md;
        z80_cs  = 1'b1; z80_we  = 1'b1; z80_addr  = za; z80_din  = zd;
        step();
        main_cs = 1'b0; main_we = 1'b0; z80_cs = 1'b0; z80_we = 1'b0;
        step();
    endtask

    task automatic main_rd(input logic [2:0] a, input logic [15:0] e, input string nm);
        q_main.push_back(e);
        q_main_nm.push_back(nm);
        main_cs = 1'b1; main_we = 1'b0; main_addr = a;
        step();
        main_cs = 1'b0;
    endtask

    task automatic z80_rd(input logic [4:0] a, input logic [7:0] e, input string nm);
        q_z80.push_back(e);
        q_z80_nm.push_back(nm);
        z80_cs = 1'b1; z80_we = 1'b0; z80_addr = a;
        step();
        z80_cs = 1'b0;
    endtask

    task automatic probe_chk(input string nm, input logic cd, input logic [15:0] md,
                             input logic [7:0] zd, input logic in_n, input logic [7:0] v);
        probe_t p;
        p.chk_dout = cd; p.md = md; p.zd = zd; p.int_n = in_n; p.vec = v;
        q_probe.push_back(p);
        q_probe_nm.push_back(nm);
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ym_irq = 1'b0;
        main_cs = 1'b0; main_we = 1'b0; main_addr = '0; main_din = '0;
        z80_cs  = 1'b0; z80_we  = 1'b0; z80_addr  = '0; z80_din  = '0;
        repeat (3) step();
        rst = 1'b0;
        probe_chk("reset", 1'b1, 16'h0000, 8'h00, 1'b1, 8'hFF);

        // Main posts two bytes and raises RST18.
        main_wr(3'd0, 8'h12);
        main_wr(3'd1, 8'h34);
        main_cs = 1'b1; main_we = 1'b1; main_addr = 3'd4; main_din = 8'h00;
        step();
        main_cs = 1'b0; main_we = 1'b0;
        probe_chk("t1_latency", 1'b0, '0, '0, 1'b1, 8'hFF);
        probe_chk("t1_rst18", 1'b0, '0, '0, 1'b0, 8'hDF);
        z80_rd(5'h10, 8'h12, "t1_m2s0");
        z80_rd(5'h11, 8'h34, "t1_m2s1");
        z80_rd(5'h12, 8'h01, "t1_m2s_pend");

        // Z80 replies.
        z80_wr(5'h18, 8'hAB);
        z80_wr(5'h19, 8'hCD);
        z80_wr(5'h00, 8'h00);
        main_rd(3'd5, 16'h0001, "t2_s2m_pend");
        main_rd(3'd2, 16'h00AB, "t2_s2m0");
        main_rd(3'd3, 16'h00CD, "t2_s2m1");
        z80_rd(5'h12, 8'h00, "t2_m2s_pend_clr");
        main_wr(3'd6, 8'h00);
        main_rd(3'd5, 16'h0000, "t2_s2m_pend_clr");
        main_rd(3'd7, 16'h0000, "t2_main_nop");
        z80_rd(5'h05, 8'hFF, "t2_z80_unmapped");
        z80_rd(5'h1F, 8'hFF, "t2_z80_top");

        // YM edge while RST18 pending, then individual acks.
        ym_irq = 1'b1;
        step();
        step();
        probe_chk("t3_both", 1'b0, '0, '0, 1'b0, 8'hD7);
        z80_wr(5'h02, 8'h00);
        probe_chk("t3_ack10", 1'b0, '0, '0, 1'b0, 8'hDF);
        z80_wr(5'h03, 8'h00);
        probe_chk("t3_ack18", 1'b0, '0, '0, 1'b1, 8'hFF);
        repeat (3) step();
        probe_chk("t3_no_reassert", 1'b0, '0, '0, 1'b1, 8'hFF);
        ym_irq = 1'b0;
        step();

        // Coincident set/clear of RST18: set wins.
        both_wr(3'd4, 8'h00, 5'h03, 8'h00);
        probe_chk("t4_set_wins", 1'b0, '0, '0, 1'b0, 8'hDF);
        z80_wr(5'h03, 8'h00);
        probe_chk("t4_ack18", 1'b0, '0, '0, 1'b1, 8'hFF);
        z80_rd(5'h12, 8'h01, "t4_m2s_pend");
        both_wr(3'd0, 8'h55, 5'h18, 8'h66);
        z80_rd(5'h10, 8'h55, "t4_dual_m2s0");
        main_rd(3'd2, 16'h0066, "t4_dual_s2m0");
        z80_wr(5'h00, 8'h00);

        // Held Z80 write gives one event; later main clear sticks.
        main_wr(3'd6, 8'h00);
        main_rd(3'd5, 16'h0000, "t5_pre");
        z80_cs = 1'b1; z80_we = 1'b1; z80_addr = 5'h00;
        step();
        main_rd(3'd5, 16'h0001, "t5_single_event");
        main_cs = 1'b1; main_we = 1'b1; main_addr = 3'd6;
        step();
        main_cs = 1'b0; main_we = 1'b0;
        step();
        step();
        z80_cs = 1'b0; z80_we = 1'b0;
        step();
        main_rd(3'd5, 16'h0000, "t5_held_no_reset");

        // Reset with requests pending and an access in flight.
        main_wr(3'd4, 8'h00);
        ym_irq = 1'b1;
        step();
        step();
        probe_chk("t6_pre", 1'b0, '0, '0, 1'b0, 8'hD7);
        rst = 1'b1;
        main_cs = 1'b1; main_we = 1'b1; main_addr = 3'd4;
        z80_cs  = 1'b1; z80_we  = 1'b1; z80_addr  = 5'h00;
        step();
        probe_chk("t6_reset", 1'b1, 16'h0000, 8'h00, 1'b1, 8'hFF);
        rst = 1'b0; ym_irq = 1'b0;
        main_cs = 1'b0; main_we = 1'b0; z80_cs = 1'b0; z80_we = 1'b0;
        step();
        step();
        probe_chk("t6_no_flag", 1'b0, '0, '0, 1'b1, 8'hFF);
        main_rd(3'd5, 16'h0000, "t6_s2m_pend");
        z80_rd(5'h12, 8'h00, "t6_m2s_pend");
        z80_rd(5'h10, 8'h00, "t6_m2s0_clr");
        main_rd(3'd2, 16'h0000, "t6_s2m0_clr");
        step();
        step();

        chk("queues_drained", 16'(q_main.size() + q_z80.size() + q_probe.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/toki_seibu_comms.md
Name: toki_seibu_comms

Overview:
- Mailbox and interrupt scheduler between the 68K main CPU and the Seibu Z80 sound CPU.
- Holds the main-to-sub and sub-to-main byte latches and both pending flags.
- Sequences the Z80 interrupt requests: RST10 from the YM3812 and RST18 from the main CPU.
- Drives the Z80 INT_n line and the IM0 vector byte. It sits between toki_main's sound chip-selects and the Z80 bus inside toki_sound.

Parameters:
- VEC_RST10, 8'hD7, opcode AND-mask applied when an RST10 request is pending
- VEC_RST18, 8'hDF, opcode AND-mask applied when an RST18 request is pending

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- main_cs  in  1  68K access to the sound window (level)
- main_we  in  1  write qualifier (level)
- main_addr  in  3  word offset, 68K A[3:1]
- main_din  in  8  68K data, low byte
- main_dout  out  16  read data {8'h00, byte}
- z80_cs  in  1  Z80 access to 0x4000–0x401F (level)
- z80_we  in  1  write qualifier (level)
- z80_addr  in  5  Z80 A[4:0]
- z80_din  in  8  Z80 write data
- z80_dout  out  8  read data
- ym_irq  in  1  YM3812 IRQ, active-high level
- z80_int_n  out  1  Z80 INT_n, low while any request is pending
- z80_vector  out  8  IM0 opcode for the interrupt acknowledge cycle
- m2s_0, m2s_1  out  8 each  main-to-sub latches (debug and sound-status tap)

Behaviour:
- Reset: clears all latches, both pending flags, both requests and both edge-detect registers.
  - After reset: main_dout=0, z80_dout=0, z80_int_n=1, z80_vector=8'hFF.
  - Reset asserted mid-access aborts the access. No flag is set by it.
- Write events act once per access, on the rising edge of (cs & we), using a registered copy of cs&we per side.
  - Holding cs&we high for N cycles gives exactly one event.
- Reads:
  - main_dout and z80_dout are registered, 1-cycle latency after cs is sampled.
  - Each output holds its last value while its cs is low.
- Main map (main_addr):
  - 0 W: m2s_0 <= din
  - 1 W: m2s_1 <= din
  - 2 R: s2m_0
  - 3 R: s2m_1
  - 4 W: rst18_req <= 1, m2s_pending <= 1 (data ignored)
  - 5 R: bit0 = s2m_pending
  - 6 W: s2m_pending <= 0
  - 7: no operation; reads return 0
- Z80 map (z80_addr):
  - 0x00 W: m2s_pending <= 0, s2m_pending <= 1
  - 0x01 W: rst10_req <= 0, rst18_req <= 0
  - 0x02 W: rst10_req <= 0
  - 0x03 W: rst18_req <= 0
  - 0x10 R: m2s_0
  - 0x11 R: m2s_1
  - 0x12 R: bit0 = m2s_pending
  - 0x18 W: s2m_0 <= din
  - 0x19 W: s2m_1 <= din
  - All other offsets: read 8'hFF, writes ignored (bank, YM and coin are decoded elsewhere)
- rst10_req is set on a rising edge of ym_irq (registered edge detect). A level held high does not re-set it after an ack.
- Interrupt output:
  - z80_vector = 8'hFF & (rst10_req ? VEC_RST10 : 8'hFF) & (rst18_req ? VEC_RST18 : 8'hFF). Registered, 1 cycle after the request changes.
  - Both pending gives 8'hD7.
  - z80_int_n = (z80_vector == 8'hFF), registered in the same cycle as z80_vector.
- Simultaneous set and clear of the same flag or request in one cycle: the set wins, so no request is lost.
  - Examples: main offset 4 together with Z80 0x03; ym edge together with 0x02; main offset 6 together with Z80 0x00.
- Simultaneous accesses from both sides to different storage both complete in that cycle. There is no stall and no wait state.

Decomposition:
- Package toki_seibu_pkg holds:
  - main offset constants MO_M2S0…MO_S2MCLR
  - Z80 offset constants ZO_PEND…ZO_S2M1
  - vector defaults
- One natural sub-module, toki_irq_sched: owns rst10/rst18 requests, the ym edge detect and the vector/INT_n generation. The top keeps the latches, decode and read muxes.

Test Plan:
- Reset, then main writes 0x12 to offset 0 and 0x34 to offset 1, then writes offset 4 -> z80_int_n=0 and z80_vector=8'hDF two cycles after the write edge; Z80 reads 0x10/0x11/0x12 give 8'h12, 8'h34, 8'h01.
- Z80 writes 8'hAB to 0x18 and 8'hCD to 0x19, then writes 0x00 -> main offset 5 reads 16'h0001, offsets 2/3 read 16'h00AB/16'h00CD, Z80 0x12 reads 8'h00; main write offset 6 -> offset 5 reads 16'h0000.
- ym_irq rises while rst18 is pending -> vector 8'hD7; Z80 writes 0x02 -> vector 8'hDF; Z80 writes 0x03 -> vector 8'hFF, z80_int_n=1; ym_irq held high throughout -> no re-assert.
- Main offset 4 write edge in the same cycle as Z80 0x03 write edge -> rst18_req stays 1, vector 8'hDF.
- z80_cs&we held for 5 cycles on 0x00 while main writes offset 6 in cycle 3 -> s2m_pending ends 0 (single Z80 event in cycle 1, main clear later); reset asserted with requests pending -> int_n=1, vector 8'hFF next cycle.
